// File: rtl/tile_address_generator.sv
// ---------------------------------------------------------------------------
// tile_address_generator
//
// Purpose:
//   Turns raster hcount/vcount into a frame-buffer read address for a row of
//   NUM_TILES side-by-side tiles (each TILE_W x TILE_H pixels). It supports
//   four scan orientations, selected once per frame. Every output is
//   registered with a fixed two-cycle latency.
//
// Ports:
//   clk_in          pixel clock
//   rst_in          asynchronous active-high reset
//   hcount_in[10:0] raster x
//   vcount_in[9:0]  raster y
//   mode_in[1:0]    orientation, sampled at (0,0): 0 fwd, 1 180deg,
//                   2 horizontal mirror, 3 vertical flip
//   addr_out        frame-buffer read address (0 when not in a tile)
//   tile_idx_out    tile being addressed (holds last valid value)
//   valid_out       addr_out/tile_idx_out refer to an in-tile pixel
//   frame_start_out one-cycle pulse, two cycles after the (0,0) input
// ---------------------------------------------------------------------------
module tile_address_generator #(
  parameter int NUM_TILES  = 4,
  parameter int TILE_W     = 240,
  parameter int TILE_H     = 320,
  parameter int TILE_PITCH = 256,
  parameter int X0         = 8,
  parameter int Y0         = 200,
  parameter int ADDR_W     = 17
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  input  logic [1:0]        mode_in,
  output logic [ADDR_W-1:0] addr_out,
  output logic [2:0]        tile_idx_out,
  output logic              valid_out,
  output logic              frame_start_out
);

  localparam int N = TILE_W * TILE_H;

  localparam logic [ADDR_W-1:0] W_STEP        = ADDR_W'(TILE_W);
  localparam logic [ADDR_W-1:0] LAST_ADDR     = ADDR_W'(N - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((TILE_H - 1) * TILE_W);
  localparam logic [ADDR_W-1:0] LAST_COL      = ADDR_W'(TILE_W - 1);

  // Elaboration-time parameter sanity checks.
  if (TILE_PITCH < TILE_W) begin : g_bad_pitch
    $error("tile_address_generator: TILE_PITCH must be >= TILE_W");
  end
  if ((longint'(TILE_W) * longint'(TILE_H)) > (longint'(1) << ADDR_W)) begin : g_bad_addr_w
    $error("tile_address_generator: TILE_W*TILE_H does not fit in ADDR_W bits");
  end
  if ((NUM_TILES < 1) || (NUM_TILES > 8)) begin : g_bad_num_tiles
    $error("tile_address_generator: NUM_TILES must be 1..8");
  end

  typedef enum logic [1:0] {
    MODE_FWD   = 2'd0,
    MODE_REV   = 2'd1,
    MODE_HMIR  = 2'd2,
    MODE_VFLIP = 2'd3
  } mode_e;

  // -------------------------------------------------------------------------
  // Raster decode
  // -------------------------------------------------------------------------
  logic [31:0]          h_ext;
  logic [31:0]          v_ext;
  logic                 frame_origin;
  logic                 in_band;
  logic [NUM_TILES-1:0] in_tile;
  logic [NUM_TILES-1:0] left_edge;
  logic                 tile_hit;
  logic                 at_left;
  logic [2:0]           tile_sel;

  assign h_ext        = 32'(hcount_in);
  assign v_ext        = 32'(vcount_in);
  assign frame_origin = (hcount_in == 11'd0) && (vcount_in == 10'd0);
  assign in_band      = (v_ext >= 32'(Y0)) && (v_ext < 32'(Y0 + TILE_H));

  for (genvar gi = 0; gi < NUM_TILES; gi++) begin : g_tile
    localparam int LEFT = X0 + gi * TILE_PITCH;
    assign in_tile[gi]   = in_band && (h_ext >= 32'(LEFT)) && (h_ext < 32'(LEFT + TILE_W));
    assign left_edge[gi] = in_band && (h_ext == 32'(LEFT));
  end

  assign tile_hit = |in_tile;
  assign at_left  = |left_edge;

  // Tiles never overlap (pitch >= width), so at most one bit is set.
  always_comb begin
    tile_sel = 3'd0;
    for (int t = 0; t < NUM_TILES; t++) begin
      if (in_tile[t]) begin
        tile_sel = 3'(t);
      end
    end
  end

  // -------------------------------------------------------------------------
  // Mode latch and running counters
  // -------------------------------------------------------------------------
  mode_e             mode_reg;
  mode_e             mode_cur;
  logic [ADDR_W-1:0] col_reg;
  logic [ADDR_W-1:0] col_next;
  logic [ADDR_W-1:0] base_reg;
  logic [ADDR_W-1:0] base_next;
  logic [9:0]        row_v_reg;   // vcount of the last left-edge reload
  logic              row_valid_reg;
  logic [ADDR_W-1:0] row_ext;
  logic [ADDR_W-1:0] row_prod;

  // The (0,0) pixel itself is already governed by the new mode.
  assign mode_cur = frame_origin ? mode_e'(mode_in) : mode_reg;

  assign row_ext = ADDR_W'(v_ext - 32'(Y0));

  // row*TILE_W as a shift-and-add over the set bits of the constant width.
  // Only used to resynchronise the row base after a vertical jump.
  always_comb begin
    row_prod = '0;
    for (int i = 0; i < ADDR_W; i++) begin
      if (W_STEP[i]) begin
        row_prod = row_prod + (row_ext << i);
      end
    end
  end

  // Column term: counts up from 0 (or down from TILE_W-1 when mirrored),
  // reloaded at every tile left edge.
  always_comb begin
    col_next = '0;
    if (at_left) begin
      col_next = (mode_cur == MODE_HMIR) ? LAST_COL : '0;
    end else begin
      col_next = (mode_cur == MODE_HMIR) ? (col_reg - 1'b1) : (col_reg + 1'b1);
    end
  end

  // Row base, already folded with the orientation so the final address is
  // simply base +/- column. It only changes at a tile left edge: constant at
  // Y0, +/-TILE_W on the next line, unchanged for further tiles on the same
  // line, and recomputed from vcount after any other vertical jump.
  always_comb begin
    base_next = base_reg;
    if (at_left) begin
      if (v_ext == 32'(Y0)) begin
        unique case (mode_cur)
          MODE_REV:   base_next = LAST_ADDR;
          MODE_VFLIP: base_next = LAST_ROW_BASE;
          default:    base_next = '0;
        endcase
      end else if (row_valid_reg && (vcount_in == row_v_reg)) begin
        base_next = base_reg;
      end else if (row_valid_reg && (vcount_in == row_v_reg + 10'd1)) begin
        unique case (mode_cur)
          MODE_REV, MODE_VFLIP: base_next = base_reg - W_STEP;
          default:              base_next = base_reg + W_STEP;
        endcase
      end else begin
        unique case (mode_cur)
          MODE_REV:   base_next = LAST_ADDR - row_prod;
          MODE_VFLIP: base_next = LAST_ROW_BASE - row_prod;
          default:    base_next = row_prod;
        endcase
      end
    end
  end

  // -------------------------------------------------------------------------
  // Pipeline: stage 1 captures counters, stage 2 forms the address.
  // -------------------------------------------------------------------------
  logic              s1_valid_reg;
  logic [2:0]        s1_tile_reg;
  logic [ADDR_W-1:0] s1_base_reg;
  logic [ADDR_W-1:0] s1_col_reg;
  logic              s1_sub_reg;
  logic              s1_frame_start_reg;
  logic [ADDR_W-1:0] addr_next;

  // 180-degree rotation walks the column backwards from the row base.
  assign addr_next = s1_sub_reg ? (s1_base_reg - s1_col_reg) : (s1_base_reg + s1_col_reg);

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mode_reg           <= MODE_FWD;
      col_reg            <= '0;
      base_reg           <= '0;
      row_v_reg          <= '0;
      row_valid_reg      <= 1'b0;
      s1_valid_reg       <= 1'b0;
      s1_tile_reg        <= '0;
      s1_base_reg        <= '0;
      s1_col_reg         <= '0;
      s1_sub_reg         <= 1'b0;
      s1_frame_start_reg <= 1'b0;
      addr_out           <= '0;
      tile_idx_out       <= '0;
      valid_out          <= 1'b0;
      frame_start_out    <= 1'b0;
    end else begin
      // A new frame may change orientation, so forget the tracked row.
      if (frame_origin) begin
        mode_reg      <= mode_e'(mode_in);
        row_valid_reg <= 1'b0;
      end
      if (tile_hit) begin
        col_reg <= col_next;
      end
      if (at_left) begin
        base_reg      <= base_next;
        row_v_reg     <= vcount_in;
        row_valid_reg <= 1'b1;
      end

      s1_valid_reg       <= tile_hit;
      s1_tile_reg        <= tile_sel;
      s1_base_reg        <= base_next;
      s1_col_reg         <= col_next;
      s1_sub_reg         <= (mode_cur == MODE_REV);
      s1_frame_start_reg <= frame_origin;

      valid_out       <= s1_valid_reg;
      addr_out        <= s1_valid_reg ? addr_next : '0;
      frame_start_out <= s1_frame_start_reg;
      if (s1_valid_reg) begin
        tile_idx_out <= s1_tile_reg;
      end
    end
  end

endmodule

// File: tb/tb_tile_address_generator.sv
// ---------------------------------------------------------------------------
// tb_tile_address_generator
//
// Two instances share clock, reset and raster inputs: dut_a uses the default
// geometry, dut_b is a small two-tile, gap-free geometry that can be swept
// over whole frames. Expected outputs for both are computed from the address
// formulas when a pixel is driven, queued, and compared two cycles later.
// ---------------------------------------------------------------------------
module tb_tile_address_generator;

  // Small geometry for the gap-free full-frame sweep.
  localparam int B_TILES = 2;
  localparam int B_W     = 12;
  localparam int B_H     = 8;
  localparam int B_PITCH = 12;
  localparam int B_X0    = 3;
  localparam int B_Y0    = 5;
  localparam int B_AW    = 7;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic [10:0] hcount_in = '0;
  logic [9:0]  vcount_in = '0;
  logic [1:0]  mode_in = '0;

  logic [16:0]     addr_a;
  logic [2:0]      tile_a;
  logic            valid_a;
  logic            fs_a;
  logic [B_AW-1:0] addr_b;
  logic [2:0]      tile_b;
  logic            valid_b;
  logic            fs_b;

  always #5 clk_in = ~clk_in;

  tile_address_generator dut_a (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .mode_in         (mode_in),
    .addr_out        (addr_a),
    .tile_idx_out    (tile_a),
    .valid_out       (valid_a),
    .frame_start_out (fs_a)
  );

  tile_address_generator #(
    .NUM_TILES  (B_TILES),
    .TILE_W     (B_W),
    .TILE_H     (B_H),
    .TILE_PITCH (B_PITCH),
    .X0         (B_X0),
    .Y0         (B_Y0),
    .ADDR_W     (B_AW)
  ) dut_b (
    .clk_in          (clk_in),
    .rst_in          (rst_in),
    .hcount_in       (hcount_in),
    .vcount_in       (vcount_in),
    .mode_in         (mode_in),
    .addr_out        (addr_b),
    .tile_idx_out    (tile_b),
    .valid_out       (valid_b),
    .frame_start_out (fs_b)
  );

  typedef struct packed {
    logic [16:0] addr;
    logic [2:0]  tile;
    logic        valid;
    logic        fs;
  } exp_t;

  typedef struct {
    exp_t a;
    exp_t b;
    int   h;
    int   v;
    int   due;
  } item_t;

  item_t      exp_q[$];
  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  int         vcnt_b = 0;
  int         fscnt_b = 0;
  logic [1:0] model_mode = 2'd0;
  logic [2:0] hold_a = 3'd0;
  logic [2:0] hold_b = 3'd0;
  item_t      mon_it;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
    end
  endtask

  // Reference model straight from the address formulas.
  function automatic exp_t model(input int h, input int v, input int m,
                                 input int x0, input int y0, input int w, input int ht,
                                 input int p, input int nt, input logic [2:0] hold);
    exp_t e;
    int   l;
    int   col;
    int   row;
    int   a;
    e.valid = 1'b0;
    e.addr  = '0;
    e.tile  = hold;
    e.fs    = (h == 0) && (v == 0);
    for (int t = 0; t < nt; t++) begin
      l = x0 + t * p;
      if ((h >= l) && (h < l + w) && (v >= y0) && (v < y0 + ht)) begin
        col = h - l;
        row = v - y0;
        case (m)
          0:       a = row * w + col;
          1:       a = w * ht - 1 - (row * w + col);
          2:       a = row * w + (w - 1 - col);
          default: a = (ht - 1 - row) * w + col;
        endcase
        e.valid = 1'b1;
        e.tile  = 3'(t);
        e.addr  = 17'(a);
      end
    end
    return e;
  endfunction

  always @(posedge clk_in) cyc <= cyc + 1;

  // Scoreboard consumer plus dut_b activity counters.
  always @(negedge clk_in) begin
    if (valid_b) vcnt_b++;
    if (fs_b) fscnt_b++;
    if ((exp_q.size() > 0) && (exp_q[0].due <= cyc)) begin
      mon_it = exp_q.pop_front();
      check($sformatf("a_addr(%0d,%0d)", mon_it.h, mon_it.v), 32'(addr_a), 32'(mon_it.a.addr));
      check($sformatf("a_tile(%0d,%0d)", mon_it.h, mon_it.v), 32'(tile_a), 32'(mon_it.a.tile));
      check($sformatf("a_valid(%0d,%0d)", mon_it.h, mon_it.v), 32'(valid_a), 32'(mon_it.a.valid));
      check($sformatf("a_fs(%0d,%0d)", mon_it.h, mon_it.v), 32'(fs_a), 32'(mon_it.a.fs));
      check($sformatf("b_addr(%0d,%0d)", mon_it.h, mon_it.v), 32'(addr_b), 32'(mon_it.b.addr));
      check($sformatf("b_tile(%0d,%0d)", mon_it.h, mon_it.v), 32'(tile_b), 32'(mon_it.b.tile));
      check($sformatf("b_valid(%0d,%0d)", mon_it.h, mon_it.v), 32'(valid_b), 32'(mon_it.b.valid));
      check($sformatf("b_fs(%0d,%0d)", mon_it.h, mon_it.v), 32'(fs_b), 32'(mon_it.b.fs));
    end
  end

  task automatic drive(input int h, input int v, input logic [1:0] m);
    item_t it;
    @(negedge clk_in);
    hcount_in = 11'(h);
    vcount_in = 10'(v);
    mode_in   = m;
    if ((h == 0) && (v == 0)) model_mode = m;
    it.a = model(h, v, int'(model_mode), 8, 200, 240, 320, 256, 4, hold_a);
    it.b = model(h, v, int'(model_mode), B_X0, B_Y0, B_W, B_H, B_PITCH, B_TILES, hold_b);
    if (it.a.valid) hold_a = it.a.tile;
    if (it.b.valid) hold_b = it.b.tile;
    it.h   = h;
    it.v   = v;
    it.due = cyc + 2;
    exp_q.push_back(it);
  endtask

  task automatic line(input int v, input int h0, input int h1, input logic [1:0] m);
    $display("seg v=%0d h=%0d..%0d mode_in=%0d", v, h0, h1, m);
    for (int h = h0; h <= h1; h++) drive(h, v, m);
  endtask

  task automatic origin(input logic [1:0] m);
    $display("frame start mode_in=%0d", m);
    drive(0, 0, m);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1100, 1000, 2'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_addr_a"}, 32'(addr_a), 32'd0);
    check({tag, "_tile_a"}, 32'(tile_a), 32'd0);
    check({tag, "_valid_a"}, 32'(valid_a), 32'd0);
    check({tag, "_fs_a"}, 32'(fs_a), 32'd0);
    check({tag, "_addr_b"}, 32'(addr_b), 32'd0);
    check({tag, "_valid_b"}, 32'(valid_b), 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  initial begin
    int vcnt_start;
    int fs_start;

    // Reset state.
    repeat (3) @(negedge clk_in);
    check_zero("reset");
    rst_in = 1'b0;

    // One frame per orientation, a few representative lines each.
    for (int m = 0; m < 4; m++) begin
      origin(2'(m));
      line(200, 0, 1019, 2'(m));
      line(201, 0, 1019, 2'(m));
      line(319, 0, 1019, 2'(m));
      line(519, 0, 1019, 2'(m));
    end

    // mode_in changes mid-frame: no effect until the next frame start.
    origin(2'd0);
    line(300, 0, 499, 2'd0);
    line(300, 500, 1019, 2'd1);
    line(301, 0, 1019, 2'd1);
    origin(2'd1);
    line(200, 0, 1019, 2'd1);
    origin(2'd0);
    line(200, 0, 1019, 2'd0);

    // Asynchronous reset in the middle of a tile.
    line(250, 0, 100, 2'd0);
    #2;
    check("pre_rst_valid_a", 32'(valid_a), 32'd1);
    rst_in = 1'b1;
    #1;
    check_zero("async_rst");
    $display("async reset asserted at h=100 v=250");
    exp_q.delete();
    model_mode = 2'd0;
    hold_a = 3'd0;
    hold_b = 3'd0;
    hcount_in = 11'd1100;
    vcount_in = 10'd1000;
    repeat (2) @(negedge clk_in);
    check_zero("rst_hold");
    rst_in = 1'b0;
    line(250, 248, 520, 2'd0);
    idle(4);

    // Full-frame sweep of the gap-free geometry in every orientation.
    @(negedge clk_in);
    vcnt_start = vcnt_b;
    fs_start   = fscnt_b;
    for (int m = 0; m < 4; m++) begin
      for (int v = 0; v < 16; v++) begin
        line(v, 0, 31, 2'(m));
      end
    end
    idle(4);
    repeat (4) @(negedge clk_in);
    check("b_valid_count", 32'(vcnt_b - vcnt_start), 32'(4 * B_TILES * B_W * B_H));
    check("b_frame_starts", 32'(fscnt_b - fs_start), 32'd4);
    check("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
